// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the streaming instruction-memory loader.
package imem_pkg;

  localparam logic [7:0] IMEM_SOF = 8'hFE;
  localparam logic [7:0] IMEM_EOF = 8'hFF;
  localparam logic [7:0] IMEM_ESC = 8'hFD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ESC  = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs a byte stream into XLEN-bit words; the merged word is presented combinationally
// so the caller can commit it on the same edge that accepts the final lane byte.
module imem_byte_assembler
  import imem_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          BIG_ENDIAN = 1'b1,
  localparam int unsigned LANES     = XLEN / 8,
  localparam int unsigned LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      byte_i,
  input  logic            push,
  input  logic            flush,
  input  logic            clear,
  output logic [XLEN-1:0] word_o,
  output logic            word_vld_o,
  output logic [LW-1:0]   lane_o
);

  logic [LW-1:0]   lane_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] merged;
  logic            last_lane;

  always_comb begin
    merged = word_q;
    if (push) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_q == LW'(i)) begin
          if (BIG_ENDIAN) merged[XLEN-1-8*i -: 8] = byte_i;
          else            merged[8*i +: 8]        = byte_i;
        end
      end
    end
  end

  assign last_lane  = (lane_q == LW'(LANES - 1));
  // Unfilled lanes of word_q are still zero, which gives the EOF zero-padding for free.
  assign word_vld_o = (push && last_lane) || (flush && (lane_q != '0));
  assign word_o     = merged;
  assign lane_o     = lane_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (clear || word_vld_o) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (push) begin
      lane_q <= lane_q + LW'(1);
      word_q <= merged;
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Instruction memory filled by a framed byte-serial loader (SOF/EOF/ESC), read
// asynchronously by the fetch stage.
module imem_stream_loader
  import imem_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 64,
  parameter bit          BIG_ENDIAN = 1'b1,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW        = $clog2(DEPTH) + 1,
  localparam int unsigned LW        = (XLEN / 8 > 1) ? $clog2(XLEN / 8) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr_i,
  output logic [XLEN-1:0] instr_o,
  input  logic [7:0]      byte_i,
  input  logic            byte_valid_i,
  output logic            load_busy_o,
  output logic            load_done_o,
  output logic            load_err_o,
  output logic [CW-1:0]   load_words_o
);

  imem_state_e     state_q, state_d;
  logic            push, flush, clear_frame, done_set;
  logic            is_sof, is_eof, is_esc;
  logic [XLEN-1:0] asm_word;
  logic            asm_vld;
  logic [LW-1:0]   lane_unused;
  logic [CW-1:0]   wr_ptr_q;
  logic            full;
  logic            done_q, err_q;
  logic [XLEN-1:0] mem [DEPTH];
  logic [29:0]     word_idx;
  logic            in_range;
  logic            addr_unused;

  assign is_sof = (byte_i == IMEM_SOF);
  assign is_eof = (byte_i == IMEM_EOF);
  assign is_esc = (byte_i == IMEM_ESC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (byte_valid_i && is_sof) state_d = LOAD;
      LOAD: if (byte_valid_i) begin
        if (is_eof)      state_d = IDLE;
        else if (is_esc) state_d = ESC;
      end
      ESC:  if (byte_valid_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push        = 1'b0;
    flush       = 1'b0;
    clear_frame = 1'b0;
    done_set    = 1'b0;
    load_busy_o = (state_q != IDLE);
    case (state_q)
      IDLE: clear_frame = byte_valid_i && is_sof;
      LOAD: if (byte_valid_i) begin
        if (is_sof) clear_frame = 1'b1;
        else if (is_eof) begin
          flush    = 1'b1;
          done_set = 1'b1;
        end else if (!is_esc) push = 1'b1;
      end
      ESC:  push = byte_valid_i;
      default: ;
    endcase
  end

  imem_byte_assembler #(
    .XLEN       (XLEN),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_i     (byte_i),
    .push       (push),
    .flush      (flush),
    .clear      (clear_frame),
    .word_o     (asm_word),
    .word_vld_o (asm_vld),
    .lane_o     (lane_unused)
  );

  // wr_ptr doubles as the committed-word count; it stops at DEPTH instead of wrapping.
  assign full = (wr_ptr_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_set;
      if (clear_frame) begin
        wr_ptr_q <= '0;
        err_q    <= 1'b0;
      end else if (asm_vld) begin
        if (full) err_q    <= 1'b1;
        else      wr_ptr_q <= wr_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (asm_vld && !full) begin
      mem[wr_ptr_q[AW-1:0]] <= asm_word;
    end
  end

  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
  assign load_words_o = wr_ptr_q;

  assign word_idx    = addr_i[31:2];
  assign addr_unused = ^addr_i[1:0];
  assign in_range    = ((word_idx >> AW) == 30'd0);
  assign instr_o     = in_range ? mem[word_idx[AW-1:0]] : '0;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench: one byte stream drives a big-endian and a little-endian loader side by side.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr_i = '0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid_i = 1'b0;

  logic [31:0] instr_be, instr_le;
  logic        busy_be, done_be, err_be;
  logic        busy_le, done_le, err_le;
  logic [6:0]  words_be, words_le;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  imem_stream_loader #(.XLEN(32), .DEPTH(64), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .addr_i(addr_i), .instr_o(instr_be),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .load_busy_o(busy_be),
    .load_done_o(done_be), .load_err_o(err_be), .load_words_o(words_be)
  );

  imem_stream_loader #(.XLEN(32), .DEPTH(64), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .addr_i(addr_i), .instr_o(instr_le),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .load_busy_o(busy_le),
    .load_done_o(done_le), .load_err_o(err_le), .load_words_o(words_le)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_i       = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  // One cycle with a control-looking byte that must be ignored (valid low).
  task automatic gap();
    @(negedge clk);
    byte_i       = 8'hFF;
    byte_valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag, input int unsigned widx,
                           input logic [31:0] exp_be, input logic [31:0] exp_le);
    addr_i = widx << 2;
    #1;
    check({tag, "_be"}, instr_be, exp_be);
    check({tag, "_le"}, instr_le, exp_le);
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done,
                              input logic err, input logic [6:0] words);
    check({tag, "_busy"},  {30'd0, busy_be, busy_le},  {30'd0, busy, busy});
    check({tag, "_done"},  {30'd0, done_be, done_le},  {30'd0, done, done});
    check({tag, "_err"},   {30'd0, err_be, err_le},    {30'd0, err, err});
    check({tag, "_words"}, {18'd0, words_be, words_le}, {18'd0, words, words});
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_status("reset", 1'b0, 1'b0, 1'b0, 7'd0);
    for (int unsigned w = 0; w < 64; w++) check_mem("reset_mem", w, 32'h0, 32'h0);
    check_mem("reset_oob", 64, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Basic frame
    send(8'hFE);
    check_status("basic_sof", 1'b1, 1'b0, 1'b0, 7'd0);
    send(8'h00); send(8'h50); send(8'h00); send(8'h93);
    check_status("basic_word", 1'b1, 1'b0, 1'b0, 7'd1);
    send(8'hFF);
    check_status("basic_eof", 1'b0, 1'b1, 1'b0, 7'd1);
    @(posedge clk); #1;
    check_status("basic_after", 1'b0, 1'b0, 1'b0, 7'd1);
    check_mem("basic_mem0", 0, 32'h00500093, 32'h93005000);
    addr_i = 32'h0000_0002;
    #1;
    check("basic_unaligned", instr_be, 32'h00500093);
    check_mem("basic_oob", 64, 32'h0, 32'h0);
    check_mem("basic_mem1", 1, 32'h0, 32'h0);

    // Escape: escaped FF must not terminate the frame
    send(8'hFE); send(8'hFD); send(8'hFF);
    check_status("esc_ff", 1'b1, 1'b0, 1'b0, 7'd0);
    send(8'hFD); send(8'hFE); send(8'hFD); send(8'hFD); send(8'h13);
    send(8'hFF);
    check_status("esc_eof", 1'b0, 1'b1, 1'b0, 7'd1);
    check_mem("esc_mem0", 0, 32'hFFFEFD13, 32'h13FDFEFF);

    // Partial word zero-padded on EOF
    send(8'hFE); send(8'hAA); send(8'hBB); send(8'hFF);
    check_status("partial", 1'b0, 1'b1, 1'b0, 7'd1);
    check_mem("partial_mem0", 0, 32'hAABB0000, 32'h0000BBAA);

    // Empty frame still pulses done
    send(8'hFE); send(8'hFF);
    check_status("empty", 1'b0, 1'b1, 1'b0, 7'd0);
    @(posedge clk); #1;
    check_status("empty_after", 1'b0, 1'b0, 1'b0, 7'd0);
    check_mem("empty_mem0", 0, 32'hAABB0000, 32'h0000BBAA);

    // Overflow: 65 words into 64 entries
    send(8'hFE);
    for (int unsigned k = 0; k < 64; k++) begin
      send(8'(k)); send(8'h11); send(8'h22); send(8'h33);
    end
    check_status("ovf_full", 1'b1, 1'b0, 1'b0, 7'd64);
    send(8'd64); send(8'h11); send(8'h22); send(8'h33);
    check_status("ovf_drop", 1'b1, 1'b0, 1'b1, 7'd64);
    send(8'hFF);
    check_status("ovf_eof", 1'b0, 1'b1, 1'b1, 7'd64);
    check_mem("ovf_mem0",  0,  32'h00112233, 32'h33221100);
    check_mem("ovf_mem31", 31, 32'h1F112233, 32'h3322111F);
    check_mem("ovf_mem63", 63, 32'h3F112233, 32'h3322113F);
    check_mem("ovf_oob",   64, 32'h0, 32'h0);
    send(8'hFE);
    check_status("ovf_restart", 1'b1, 1'b0, 1'b0, 7'd0);
    send(8'hFF);

    // Gapped stream with ignored control bytes between valid cycles
    send(8'hFE); gap(); send(8'h12); gap(); send(8'h34); gap();
    send(8'h56); gap(); send(8'h78); gap();
    check_status("gap_word", 1'b1, 1'b0, 1'b0, 7'd1);
    send(8'hFF);
    check_status("gap_eof", 1'b0, 1'b1, 1'b0, 7'd1);
    check_mem("gap_mem0", 0, 32'h12345678, 32'h78563412);
    check_mem("gap_mem1", 1, 32'h01112233, 32'h33221101);

    // Mid-frame asynchronous reset
    send(8'hFE); send(8'h01); send(8'h02);
    #2 reset = 1'b0;
    #1;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 7'd0);
    check_mem("midrst_mem0", 0, 32'h0, 32'h0);
    check_mem("midrst_mem63", 63, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    send(8'hAB); send(8'hCD); send(8'hEF); send(8'h01);
    check_status("nosof", 1'b0, 1'b0, 1'b0, 7'd0);
    check_mem("nosof_mem0", 0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
